// File: rtl/parking_gate_ctrl.sv
// Lane controller: debounces entry/exit loop sensors, sequences both barriers, emits one inc/dec pulse per passage.
// Latency: gate opens DEBOUNCE_CYCLES+2 edges after a stable raw request; car pulse registered one edge after COMMIT.
// Backpressure: the shared pulse path is arbitrated (entry first); a losing exit lane holds in COMMIT one extra cycle.
//
// Ports: clk, reset (sync, active-low); raw sensors entry_req/entry_clear/exit_req/exit_clear;
//        free_slots from the parking counter; gate commands; inc_car/dec_car/entry_denied pulses; full flag.
module parking_gate_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       entry_clear,
    input  logic       exit_req,
    input  logic       exit_clear,
    input  logic [3:0] free_slots,
    output logic       entry_gate_open,
    output logic       exit_gate_open,
    output logic       inc_car,
    output logic       dec_car,
    output logic       entry_denied,
    output logic       full
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        PASS   = 2'd2,
        COMMIT = 2'd3
    } lane_state_t;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Sensor index map: 0 entry_req, 1 entry_clear, 2 exit_req, 3 exit_clear
    logic [3:0] raw_in;
    logic [3:0] raw_q;
    logic [3:0] deb_lvl;
    logic [3:0] deb_cnt [4];
    logic       entry_req_d;
    logic       exit_req_d;

    assign raw_in = {exit_clear, exit_req, entry_clear, entry_req};

    // Input register, then a per-sensor run counter: the level flips only once
    // DEBOUNCE_CYCLES consecutive registered samples disagree with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            raw_q       <= '0;
            deb_lvl     <= '0;
            entry_req_d <= 1'b0;
            exit_req_d  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            raw_q       <= raw_in;
            entry_req_d <= deb_lvl[0];
            exit_req_d  <= deb_lvl[2];
            for (int i = 0; i < 4; i++) begin
                if (raw_q[i] != deb_lvl[i]) begin
                    if (deb_cnt[i] == DB_LAST) begin
                        deb_lvl[i] <= raw_q[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 4'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Request events are rising edges of the debounced level only, so a held
    // sensor cannot retrigger a lane.
    logic entry_ev;
    logic exit_ev;
    assign entry_ev = deb_lvl[0] & ~entry_req_d;
    assign exit_ev  = deb_lvl[2] & ~exit_req_d;

    lane_state_t entry_state, entry_next;
    lane_state_t exit_state,  exit_next;
    logic [7:0]  entry_tmr,   entry_tmr_next;
    logic [7:0]  exit_tmr,    exit_tmr_next;
    logic        entry_grant;
    logic        exit_grant;
    logic        denied_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_state  <= IDLE;
            exit_state   <= IDLE;
            entry_tmr    <= '0;
            exit_tmr     <= '0;
            inc_car      <= 1'b0;
            dec_car      <= 1'b0;
            entry_denied <= 1'b0;
            full         <= 1'b0;
        end else begin
            entry_state  <= entry_next;
            exit_state   <= exit_next;
            entry_tmr    <= entry_tmr_next;
            exit_tmr     <= exit_tmr_next;
            inc_car      <= entry_grant;
            dec_car      <= exit_grant;
            entry_denied <= denied_next;
            full         <= (free_slots == 4'd0);
        end
    end

    always_comb begin
        entry_next     = entry_state;
        exit_next      = exit_state;
        entry_tmr_next = entry_tmr;
        exit_tmr_next  = exit_tmr;
        denied_next    = 1'b0;
        // Entry wins the pulse path; exit waits a cycle so the pulses never overlap.
        entry_grant    = (entry_state == COMMIT);
        exit_grant     = (exit_state == COMMIT) && !entry_grant;

        unique case (entry_state)
            IDLE: begin
                entry_tmr_next = '0;
                if (entry_ev) begin
                    if (free_slots != 4'd0) begin
                        entry_next = OPEN;
                    end else begin
                        denied_next = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (deb_lvl[1]) begin
                    entry_next = PASS;
                end else if (entry_tmr == TO_LAST) begin
                    entry_next = IDLE;
                end else begin
                    entry_tmr_next = entry_tmr + 8'd1;
                end
            end
            PASS: begin
                if (!deb_lvl[1]) begin
                    entry_next = COMMIT;
                end
            end
            COMMIT: begin
                if (entry_grant) begin
                    entry_next = IDLE;
                end
            end
            default: entry_next = IDLE;
        endcase

        unique case (exit_state)
            IDLE: begin
                exit_tmr_next = '0;
                if (exit_ev) begin
                    exit_next = OPEN;
                end
            end
            OPEN: begin
                if (deb_lvl[3]) begin
                    exit_next = PASS;
                end else if (exit_tmr == TO_LAST) begin
                    exit_next = IDLE;
                end else begin
                    exit_tmr_next = exit_tmr + 8'd1;
                end
            end
            PASS: begin
                if (!deb_lvl[3]) begin
                    exit_next = COMMIT;
                end
            end
            COMMIT: begin
                if (exit_grant) begin
                    exit_next = IDLE;
                end
            end
            default: exit_next = IDLE;
        endcase
    end

    // Barrier is up only while waiting for or carrying a car; COMMIT drops it.
    assign entry_gate_open = (entry_state == OPEN) || (entry_state == PASS);
    assign exit_gate_open  = (exit_state == OPEN)  || (exit_state == PASS);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios with literal expectations, then random sensor traffic.
// A behavioural model predicts every output after every edge; one process compares each cycle.
// Sensors are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_parking_gate_ctrl;

    localparam int DB = 4;
    localparam int TO = 32;
    localparam logic [15:0] WMASK = 16'((1 << DB) - 1);
    localparam int P_IDLE = 0;
    localparam int P_OPEN = 1;
    localparam int P_PASS = 2;
    localparam int P_OWED = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_req = 1'b0;
    logic       entry_clear = 1'b0;
    logic       exit_req = 1'b0;
    logic       exit_clear = 1'b0;
    logic [3:0] free_slots = 4'd3;
    logic       entry_gate_open;
    logic       exit_gate_open;
    logic       inc_car;
    logic       dec_car;
    logic       entry_denied;
    logic       full;

    parking_gate_ctrl #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .entry_req       (entry_req),
        .entry_clear     (entry_clear),
        .exit_req        (exit_req),
        .exit_clear      (exit_clear),
        .free_slots      (free_slots),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .inc_car         (inc_car),
        .dec_car         (dec_car),
        .entry_denied    (entry_denied),
        .full            (full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_sreg [4];
    logic [15:0] m_hist [4];
    int          m_nv   [4];
    bit          m_lvl  [4];
    bit          m_prev [4];
    int          m_phase[2];
    int          m_open_at[2];
    bit          e_gate [2];
    bit          e_inc, e_dec, e_deny, e_full;

    task automatic model_step();
        bit raw [4];
        bit owed0, owed1, ev;
        raw[0] = entry_req; raw[1] = entry_clear; raw[2] = exit_req; raw[3] = exit_clear;
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                m_sreg[i] = 0; m_hist[i] = '0; m_nv[i] = 0; m_lvl[i] = 0; m_prev[i] = 0;
            end
            for (int l = 0; l < 2; l++) begin
                m_phase[l] = P_IDLE; e_gate[l] = 0;
            end
            e_inc = 0; e_dec = 0; e_deny = 0; e_full = 0;
            return;
        end
        owed0  = (m_phase[0] == P_OWED);
        owed1  = (m_phase[1] == P_OWED);
        e_inc  = owed0;
        e_dec  = owed1 && !owed0;
        e_deny = 0;
        e_full = (free_slots == 4'd0);
        for (int l = 0; l < 2; l++) begin
            ev = m_lvl[2*l] && !m_prev[2*l];
            case (m_phase[l])
                P_IDLE: if (ev) begin
                    if (l == 1 || free_slots != 4'd0) begin
                        m_phase[l] = P_OPEN; m_open_at[l] = cyc;
                    end else begin
                        e_deny = 1;
                    end
                end
                P_OPEN: begin
                    if (m_lvl[2*l+1]) m_phase[l] = P_PASS;
                    else if (cyc - m_open_at[l] == TO) m_phase[l] = P_IDLE;
                end
                P_PASS: if (!m_lvl[2*l+1]) m_phase[l] = P_OWED;
                default: if (l == 0 || !owed0) m_phase[l] = P_IDLE;
            endcase
            e_gate[l] = (m_phase[l] == P_OPEN) || (m_phase[l] == P_PASS);
        end
        // Level flips when the last DB registered samples all disagree with it.
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = m_lvl[i];
            m_hist[i] = {m_hist[i][14:0], m_sreg[i]};
            if (m_nv[i] < 16) m_nv[i]++;
            if (m_nv[i] >= DB && ((m_hist[i] ^ {16{m_lvl[i]}}) & WMASK) == WMASK)
                m_lvl[i] = !m_lvl[i];
            m_sreg[i] = raw[i];
        end
    endtask

    // Observation counters used by the directed scenarios
    int n_inc = 0, n_dec = 0, n_deny = 0, n_gate_en = 0, n_gate_ex = 0, n_both = 0;
    int last_inc = 0, last_dec = 0;

    always begin
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check("entry_gate_open", entry_gate_open, e_gate[0]);
        check("exit_gate_open",  exit_gate_open,  e_gate[1]);
        check("inc_car",         inc_car,         e_inc);
        check("dec_car",         dec_car,         e_dec);
        check("entry_denied",    entry_denied,    e_deny);
        check("full",            full,            e_full);
        check("inc_dec_exclusive", inc_car & dec_car, 1'b0);
        if (inc_car === 1'b1) begin n_inc++; last_inc = cyc; end
        if (dec_car === 1'b1) begin n_dec++; last_dec = cyc; end
        if (inc_car === 1'b1 && dec_car === 1'b1) n_both++;
        n_deny    += (entry_denied === 1'b1) ? 1 : 0;
        n_gate_en += (entry_gate_open === 1'b1) ? 1 : 0;
        n_gate_ex += (exit_gate_open === 1'b1) ? 1 : 0;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_counts();
        n_inc = 0; n_dec = 0; n_deny = 0; n_gate_en = 0; n_gate_ex = 0; n_both = 0;
        last_inc = 0; last_dec = 0;
    endtask

    initial begin
        int start, first;
        tick(2);
        reset = 1'b1;
        check("reset_gate", entry_gate_open, 1'b0);
        check("reset_full", full, 1'b0);
        tick(2);

        // Normal entry: gate must rise on edge 6 after the raw request
        clr_counts();
        entry_req = 1'b1;
        start = cyc;
        first = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (entry_gate_open === 1'b1 && first == 0) first = cyc - start;
        end
        check("entry_open_edge", first, 6);
        entry_req = 1'b0;
        entry_clear = 1'b1;
        tick(10);
        entry_clear = 1'b0;
        tick(20);
        check("entry_inc_count", n_inc, 1);
        check("entry_dec_count", n_dec, 0);
        check("entry_gate_closed", entry_gate_open, 1'b0);

        // Glitch rejection
        tick(10);
        clr_counts();
        entry_req = 1'b1;
        tick(3);
        entry_req = 1'b0;
        tick(15);
        check("glitch_gate_cycles", n_gate_en, 0);
        check("glitch_pulses", n_inc + n_dec + n_deny, 0);

        // Full lot
        free_slots = 4'd0;
        tick(2);
        clr_counts();
        entry_req = 1'b1;
        tick(30);
        check("full_denied_count", n_deny, 1);
        check("full_flag", full, 1'b1);
        check("full_gate_cycles", n_gate_en, 0);
        entry_req = 1'b0;
        free_slots = 4'd5;
        tick(10);

        // Simultaneous commits
        clr_counts();
        entry_req = 1'b1;
        exit_req = 1'b1;
        tick(8);
        check("sim_entry_open", entry_gate_open, 1'b1);
        check("sim_exit_open", exit_gate_open, 1'b1);
        entry_req = 1'b0; exit_req = 1'b0;
        entry_clear = 1'b1; exit_clear = 1'b1;
        tick(8);
        entry_clear = 1'b0; exit_clear = 1'b0;
        tick(20);
        check("sim_inc_count", n_inc, 1);
        check("sim_dec_count", n_dec, 1);
        check("sim_dec_after_inc", last_dec - last_inc, 1);
        check("sim_both_high", n_both, 0);

        // Exit timeout
        clr_counts();
        exit_req = 1'b1;
        tick(10);
        exit_req = 1'b0;
        tick(60);
        check("timeout_open_cycles", n_gate_ex, TO);
        check("timeout_dec_count", n_dec, 0);

        // Reset mid-passage
        clr_counts();
        entry_req = 1'b1;
        tick(8);
        entry_req = 1'b0;
        entry_clear = 1'b1;
        tick(8);
        check("pass_gate_open", entry_gate_open, 1'b1);
        reset = 1'b0;
        tick(1);
        check("rst_entry_gate", entry_gate_open, 1'b0);
        check("rst_exit_gate", exit_gate_open, 1'b0);
        check("rst_pulses", {inc_car, dec_car, entry_denied}, 3'b000);
        check("rst_full", full, 1'b0);
        reset = 1'b1;
        tick(3);
        entry_clear = 1'b0;
        tick(20);
        check("rst_lost_inc", n_inc, 0);

        // Random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 11) == 0) entry_req   = ~entry_req;
            if ($urandom_range(0, 11) == 0) entry_clear = ~entry_clear;
            if ($urandom_range(0, 11) == 0) exit_req    = ~exit_req;
            if ($urandom_range(0, 11) == 0) exit_clear  = ~exit_clear;
            if ($urandom_range(0, 19) == 0)
                free_slots = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        reset = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
